// File: rtl/instr_commit_multi_if.sv
// Shared ROB-entry / store-request types and the commit-stage bus.
// master = ROB/CP0/LSU side, slave = commit unit.
package instr_commit_pkg;
    typedef enum logic [2:0] {
        FU_ALU    = 3'd0,
        FU_MUL    = 3'd1,
        FU_CP0    = 3'd2,
        FU_STORE  = 3'd3,
        FU_LOAD   = 3'd4,
        FU_BRANCH = 3'd5
    } fu_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } data_memreq_t;

    typedef struct packed {
        data_memreq_t memreq;
    } rob_data_t;

    typedef struct packed {
        logic        valid;
        logic        busy;
        fu_t         fu;
        logic [4:0]  dest;
        logic [31:0] value;
        logic [31:0] pc;
        logic        need_flush;
        logic        ex_valid;
        rob_data_t   data;
    } rob_entry_t;
endpackage

interface instr_commit_multi_if #(
    parameter int COMMIT_WIDTH = 2
);
    localparam int ACK_W  = $clog2(COMMIT_WIDTH + 1);
    localparam int SLOT_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;

    instr_commit_pkg::rob_entry_t [COMMIT_WIDTH-1:0] rob_packet;
    logic                               rob_empty;
    logic [31:0]                        except_vec;
    logic                               lsu_store_full;

    logic [ACK_W-1:0]                   rob_ack_cnt;
    logic [COMMIT_WIDTH-1:0]            reg_we;
    logic [COMMIT_WIDTH-1:0][4:0]       reg_waddr;
    logic [COMMIT_WIDTH-1:0][31:0]      reg_wdata;
    instr_commit_pkg::data_memreq_t     lsu_store_memreq;
    logic                               lsu_store_push;
    logic                               commit_mul;
    logic                               commit_cp0;
    logic                               except_req_valid;
    logic [SLOT_W-1:0]                  except_slot;
    logic [31:0]                        except_pc;
    logic                               commit_flush;
    logic [31:0]                        commit_flush_pc;
    logic [31:0]                        perf_retired;

    modport master (
        output rob_packet, rob_empty, except_vec, lsu_store_full,
        input  rob_ack_cnt, reg_we, reg_waddr, reg_wdata, lsu_store_memreq,
               lsu_store_push, commit_mul, commit_cp0, except_req_valid,
               except_slot, except_pc, commit_flush, commit_flush_pc, perf_retired
    );

    modport slave (
        input  rob_packet, rob_empty, except_vec, lsu_store_full,
        output rob_ack_cnt, reg_we, reg_waddr, reg_wdata, lsu_store_memreq,
               lsu_store_push, commit_mul, commit_cp0, except_req_valid,
               except_slot, except_pc, commit_flush, commit_flush_pc, perf_retired
    );
endinterface

// File: rtl/instr_commit_multi.sv
// Multi-slot in-order commit: retires the ROB head prefix, raises exceptions/flushes.
// Optional retired-instruction counter enabled by `define COMMIT_PERF_CNT_EN.
module instr_commit_multi
    import instr_commit_pkg::*;
#(
    parameter int COMMIT_WIDTH = 2,
    parameter int FLUSH_WAIT   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_commit_multi_if.slave  bus
);
    localparam int ACK_W  = $clog2(COMMIT_WIDTH + 1);
    localparam int SLOT_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_WAIT} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_wait_cnt, w_wait_cnt_nxt;
    logic [31:0] r_flush_pc, w_flush_pc_nxt;

    logic [COMMIT_WIDTH-1:0] w_retire;
    logic [COMMIT_WIDTH-1:0] w_we;
    logic [ACK_W-1:0]        w_ack;
    logic                    w_stop;
    logic                    w_exc_hit, w_nf_hit;
    logic [SLOT_W-1:0]       w_exc_slot;
    logic [31:0]             w_exc_pc, w_nf_pc;
    logic                    w_st_hit, w_mul_hit, w_cp0_hit;
    data_memreq_t            w_st_req;
    logic                    w_active;

    // Walk the head oldest-first; the first slot that cannot retire ends the prefix.
    always_comb begin
        w_retire   = '0;
        w_ack      = '0;
        w_stop     = 1'b0;
        w_exc_hit  = 1'b0;
        w_exc_slot = '0;
        w_exc_pc   = '0;
        w_nf_hit   = 1'b0;
        w_nf_pc    = '0;
        w_st_hit   = 1'b0;
        w_mul_hit  = 1'b0;
        w_cp0_hit  = 1'b0;
        w_st_req   = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (!w_stop) begin
                if (!bus.rob_packet[i].valid || bus.rob_packet[i].busy || bus.rob_empty) begin
                    w_stop = 1'b1;
                end else if (bus.rob_packet[i].ex_valid) begin
                    w_exc_hit  = 1'b1;
                    w_exc_slot = SLOT_W'(i);
                    w_exc_pc   = bus.rob_packet[i].pc;
                    w_stop     = 1'b1;
                end else if ((bus.rob_packet[i].fu == FU_STORE && (w_st_hit || bus.lsu_store_full)) ||
                             (bus.rob_packet[i].fu == FU_MUL   && w_mul_hit) ||
                             (bus.rob_packet[i].fu == FU_CP0   && w_cp0_hit)) begin
                    w_stop = 1'b1;
                end else begin
                    w_retire[i] = 1'b1;
                    w_ack       = w_ack + ACK_W'(1);
                    if (bus.rob_packet[i].fu == FU_STORE) begin
                        w_st_hit = 1'b1;
                        w_st_req = bus.rob_packet[i].data.memreq;
                    end
                    if (bus.rob_packet[i].fu == FU_MUL) w_mul_hit = 1'b1;
                    if (bus.rob_packet[i].fu == FU_CP0) w_cp0_hit = 1'b1;
                    if (bus.rob_packet[i].need_flush) begin
                        w_nf_hit = 1'b1;
                        w_nf_pc  = bus.rob_packet[i].pc + 32'd4;
                        w_stop   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_flush_pc <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_flush_pc <= w_flush_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_flush_pc_nxt = r_flush_pc;
        unique case (r_state)
            S_IDLE: begin
                if (w_exc_hit) begin
                    w_state_nxt    = S_FLUSH;
                    w_flush_pc_nxt = bus.except_vec;
                end else if (w_nf_hit) begin
                    w_state_nxt    = S_FLUSH;
                    w_flush_pc_nxt = w_nf_pc;
                end
            end
            S_FLUSH: begin
                if (FLUSH_WAIT == 0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt    = S_WAIT;
                    w_wait_cnt_nxt = 4'(FLUSH_WAIT);
                end
            end
            S_WAIT: begin
                if (r_wait_cnt <= 4'd1) begin
                    w_state_nxt    = S_IDLE;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Commit side effects only leave the block in IDLE and out of reset.
    assign w_active = rst_n && (r_state == S_IDLE);

    for (genvar g = 0; g < COMMIT_WIDTH; g++) begin : g_slot
        assign w_we[g] = w_active && w_retire[g] && (bus.rob_packet[g].dest != 5'd0) &&
                         (bus.rob_packet[g].fu != FU_STORE);
        assign bus.reg_we[g]    = w_we[g];
        assign bus.reg_waddr[g] = w_we[g] ? bus.rob_packet[g].dest  : 5'd0;
        assign bus.reg_wdata[g] = w_we[g] ? bus.rob_packet[g].value : 32'd0;
    end

    assign bus.rob_ack_cnt      = w_active ? w_ack : '0;
    assign bus.lsu_store_push   = w_active && w_st_hit;
    assign bus.lsu_store_memreq = (w_active && w_st_hit) ? w_st_req : '0;
    assign bus.commit_mul       = w_active && w_mul_hit;
    assign bus.commit_cp0       = w_active && w_cp0_hit;
    assign bus.except_req_valid = w_active && w_exc_hit;
    assign bus.except_slot      = (w_active && w_exc_hit) ? w_exc_slot : '0;
    assign bus.except_pc        = (w_active && w_exc_hit) ? w_exc_pc   : 32'd0;
    assign bus.commit_flush     = rst_n && (r_state == S_FLUSH);
    assign bus.commit_flush_pc  = (rst_n && (r_state == S_FLUSH)) ? r_flush_pc : 32'd0;

`ifdef COMMIT_PERF_CNT_EN
    logic [31:0] r_perf;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_perf <= '0;
        else        r_perf <= r_perf + 32'(bus.rob_ack_cnt);
    end
    assign bus.perf_retired = r_perf;
`else
    assign bus.perf_retired = 32'd0;
`endif
endmodule
